// File: rtl/dano_mc_cpu.sv
// Multi-cycle schoolRISCV core with a req/valid instruction fetch, run/stop control and fetch watchdog.
// Optional perf counters (perfCycles, perfInstret) are built when DANO_MC_CPU_PERF_CNT_EN is defined.
module dano_mc_cpu #(
  parameter int ADDR_W        = 30,
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rstPC,
  input  logic              run,
  output logic              imReq,
  output logic [ADDR_W-1:0] imAddr,
  input  logic [31:0]       imData,
  input  logic              imDataVld,
  input  logic [4:0]        regAddr,
  output logic [31:0]       regData,
  output logic              halted,
  output logic              fetchErr
`ifdef DANO_MC_CPU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perfCycles,
  output logic [CNT_W-1:0]  perfInstret
`endif
);

  localparam int TO_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERROR} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_OR, ALU_SRL, ALU_SLTU, ALU_SUB} aluCtl_t;

  state_t          state, nextState;
  logic [31:0]     pc, ir, pcNext;
  logic [TO_W-1:0] toCnt;
  logic [31:0]     rf [32];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] immI, immB, immU;
  logic [31:0] rd1, rd2, srcB, aluResult, wd3;
  logic        regWrite, aluSrc, wdSrc, branch, condZero, aluZero, pcSrc, we3;
  aluCtl_t     aluCtl;

  function automatic logic [31:0] aluOp(input aluCtl_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_OR:   aluOp = a | b;
      ALU_SRL:  aluOp = a >> b[4:0];
      ALU_SLTU: aluOp = (a < b) ? 32'd1 : 32'd0;
      ALU_SUB:  aluOp = a - b;
      default:  aluOp = a + b;
    endcase
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // next-state logic; run is only looked at in IDLE and when leaving EXEC
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (run) nextState = FETCH;
      FETCH: begin
        if (imDataVld)                                   nextState = EXEC;
        else if (FETCH_TIMEOUT != 0 && toCnt == TO_LAST) nextState = ERROR;
      end
      EXEC:  nextState = run ? FETCH : IDLE;
      default: nextState = ERROR;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    imReq    = 1'b0;
    halted   = 1'b0;
    fetchErr = 1'b0;
    case (state)
      IDLE:    halted   = 1'b1;
      FETCH:   imReq    = 1'b1;
      ERROR:   fetchErr = 1'b1;
      default: ;
    endcase
  end

  // fetch stage: pc, instruction register and watchdog counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= rstPC;
      ir    <= '0;
      toCnt <= '0;
    end else begin
      if (state == FETCH) begin
        if (imDataVld) begin
          ir    <= imData;
          toCnt <= '0;
        end else begin
          toCnt <= toCnt + 1'b1;
        end
      end
      if (state == EXEC) pc <= pcNext;
    end
  end

  assign imAddr = pc[ADDR_W+1:2];

  // decode, fed only from the instruction register
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign immI   = {{20{ir[31]}}, ir[31:20]};
  assign immB   = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign immU   = {ir[31:12], 12'b0};

  always_comb begin
    regWrite = 1'b0;
    aluSrc   = 1'b0;
    wdSrc    = 1'b0;
    branch   = 1'b0;
    condZero = 1'b0;
    aluCtl   = ALU_ADD;
    case (opcode)
      7'b0110011: begin
        regWrite = 1'b1;
        case (funct3)
          3'b000:  aluCtl = (funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
          3'b110:  aluCtl = ALU_OR;
          3'b101:  aluCtl = ALU_SRL;
          3'b011:  aluCtl = ALU_SLTU;
          default: regWrite = 1'b0;
        endcase
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          regWrite = 1'b1;
          aluSrc   = 1'b1;
        end
      end
      7'b0110111: begin
        regWrite = 1'b1;
        wdSrc    = 1'b1;
      end
      7'b1100011: begin
        aluCtl = ALU_SUB;
        case (funct3)
          3'b000:  begin branch = 1'b1; condZero = 1'b1; end
          3'b001:  branch = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // execute: ALU, branch decision and write-back
  assign rd1       = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rd2       = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign srcB      = aluSrc ? immI : rd2;
  assign aluResult = aluOp(aluCtl, rd1, srcB);
  assign aluZero   = (aluResult == 32'd0);
  assign pcSrc     = branch && (aluZero == condZero);
  assign pcNext    = pcSrc ? (pc + immB) : (pc + 32'd4);
  assign wd3       = wdSrc ? immU : aluResult;

  // a reset landing on the EXEC edge must drop the pending write
  assign we3 = regWrite && (state == EXEC) && rst;

  always_ff @(posedge clk) begin
    if (we3 && rd != 5'd0) rf[rd] <= wd3;
  end

  assign regData = (regAddr == 5'd0) ? pc : rf[regAddr];

`ifdef DANO_MC_CPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perfCycles  <= '0;
      perfInstret <= '0;
    end else if (state != ERROR) begin
      perfCycles <= perfCycles + 1'b1;
      if (state == EXEC) perfInstret <= perfInstret + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dano_mc_cpu.sv
// Directed bench for dano_mc_cpu: instruction table plus hand-written fetch/run/reset sequences.
// Perf-counter checks are compiled in when DANO_MC_CPU_PERF_CNT_EN is defined.
module tb_dano_mc_cpu;

  logic        clk = 1'b0;
  logic        rst, run, imReq, imDataVld, halted, fetchErr;
  logic [31:0] rstPC, imData, regData;
  logic [29:0] imAddr;
  logic [4:0]  regAddr;
`ifdef DANO_MC_CPU_PERF_CNT_EN
  logic [31:0] perfCycles, perfInstret;
`endif

  int nChecks = 0;
  int nFails  = 0;
  int memLat  = 1;
  int fcnt    = 0;
  logic [31:0] mem [256];

  dano_mc_cpu #(.ADDR_W(30), .FETCH_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rstPC(rstPC), .run(run),
    .imReq(imReq), .imAddr(imAddr), .imData(imData), .imDataVld(imDataVld),
    .regAddr(regAddr), .regData(regData), .halted(halted), .fetchErr(fetchErr)
`ifdef DANO_MC_CPU_PERF_CNT_EN
    , .perfCycles(perfCycles), .perfInstret(perfInstret)
`endif
  );

  always #5 clk = ~clk;

  // instruction memory: data valid on the memLat-th FETCH cycle, garbage outside FETCH
  always @(negedge clk) begin
    if (imReq === 1'b1) begin
      fcnt++;
      imDataVld = (memLat != 0) && (fcnt >= memLat);
      imData    = mem[imAddr[7:0]];
    end else begin
      fcnt      = 0;
      imDataVld = 1'b0;
      imData    = 32'hDEADBEEF;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] encB(input int off, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
    logic [12:0] o;
    o = off[12:0];
    return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encU(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] v);
    regAddr = a;
    #1;
    v = regData;
    regAddr = 5'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  chkReg;
    logic [31:0] expVal;
    logic [31:0] nextPc;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] v;
    int n;

    tbl[0]  = '{32'h100, encI(12'd5, 5'd0, 3'd0, 5'd1),               5'd1,  32'd5,        32'h104};
    tbl[1]  = '{32'h104, encI(12'd3, 5'd1, 3'd0, 5'd2),               5'd2,  32'd8,        32'h108};
    tbl[2]  = '{32'h108, encR(7'd0, 5'd2, 5'd1, 3'd0, 5'd3),          5'd3,  32'd13,       32'h10C};
    tbl[3]  = '{32'h10C, encR(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd4),    5'd4,  32'hFFFFFFFD, 32'h110};
    tbl[4]  = '{32'h110, encR(7'd0, 5'd2, 5'd1, 3'd6, 5'd5),          5'd5,  32'd13,       32'h114};
    tbl[5]  = '{32'h114, encR(7'd0, 5'd2, 5'd1, 3'd3, 5'd6),          5'd6,  32'd1,        32'h118};
    tbl[6]  = '{32'h118, encR(7'd0, 5'd1, 5'd2, 3'd3, 5'd7),          5'd7,  32'd0,        32'h11C};
    tbl[7]  = '{32'h11C, encR(7'd0, 5'd1, 5'd4, 3'd5, 5'd8),          5'd8,  32'h07FFFFFF, 32'h120};
    tbl[8]  = '{32'h120, encU(20'h12345, 5'd9),                       5'd9,  32'h12345000, 32'h124};
    tbl[9]  = '{32'h124, encI(12'd7, 5'd0, 3'd0, 5'd0),               5'd1,  32'd5,        32'h128};
    tbl[10] = '{32'h128, encR(7'd0, 5'd0, 5'd0, 3'd0, 5'd10),         5'd10, 32'd0,        32'h12C};
    tbl[11] = '{32'h12C, encI(12'hFFF, 5'd0, 3'd0, 5'd11),            5'd11, 32'hFFFFFFFF, 32'h130};
    tbl[12] = '{32'h130, encB(8, 5'd2, 5'd1, 3'd1),                   5'd11, 32'hFFFFFFFF, 32'h138};
    tbl[13] = '{32'h138, encB(8, 5'd2, 5'd1, 3'd0),                   5'd1,  32'd5,        32'h13C};
    tbl[14] = '{32'h13C, encI(12'd127, 5'd0, 3'd0, 5'd13),            5'd13, 32'd127,      32'h140};
    tbl[15] = '{32'h140, encR(7'd0, 5'd11, 5'd1, 3'd3, 5'd15),        5'd15, 32'd1,        32'h144};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem[tbl[i].pc[9:2]] = tbl[i].instr;
    mem[8'h4D] = encI(12'd1, 5'd0, 3'd0, 5'd12);
    mem[8'h51] = encI(12'd9, 5'd0, 3'd0, 5'd16);
    mem[8'h52] = encI(12'd1, 5'd16, 3'd0, 5'd17);
    mem[8'h80] = encB(0, 5'd0, 5'd0, 3'd0);
    mem[8'hC0] = encI(12'h011, 5'd0, 3'd0, 5'd20);
    mem[8'hC1] = encI(12'h055, 5'd0, 3'd0, 5'd20);

    rst = 1'b0; run = 1'b0; rstPC = 32'h100; regAddr = 5'd0;
    imData = 32'h0; imDataVld = 1'b0;

    // reset and idle with run low
    repeat (2) cyc();
    chk("rst_halted", halted, 1'b1);
    chk("rst_imReq", imReq, 1'b0);
    chk("rst_fetchErr", fetchErr, 1'b0);
    chk("rst_pc", regData, 32'h100);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("idle_halted", halted, 1'b1);
      chk("idle_imReq", imReq, 1'b0);
      chk("idle_pc", regData, 32'h100);
    end
`ifdef DANO_MC_CPU_PERF_CNT_EN
    chk("idle_perfCycles", perfCycles, 32'd4);
    chk("idle_perfInstret", perfInstret, 32'd0);
`endif

    // table-driven program, zero-wait memory
    rst = 1'b0; memLat = 1;
    cyc();
    rst = 1'b1; run = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t%0d_imReq", i), imReq, 1'b1);
      chk($sformatf("t%0d_imAddr", i), {2'b0, imAddr}, tbl[i].pc >> 2);
      cyc();
      cyc();
      readReg(tbl[i].chkReg, v);
      chk($sformatf("t%0d_x%0d", i, tbl[i].chkReg), v, tbl[i].expVal);
      readReg(5'd0, v);
      chk($sformatf("t%0d_pc", i), v, tbl[i].nextPc);
`ifdef DANO_MC_CPU_PERF_CNT_EN
      if (i == 9) begin
        chk("perf_instret10", perfInstret, 32'd10);
        chk("perf_cycles21", perfCycles, 32'd21);
      end
`endif
    end

    // drop run mid-FETCH with a 3-cycle memory: the instruction still retires
    memLat = 3;
    run = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 12) begin
      cyc();
      n++;
    end
    chk("stop_halted", halted, 1'b1);
    chk("stop_cycles", n, 32'd4);
    readReg(5'd16, v);
    chk("stop_x16", v, 32'd9);
    readReg(5'd0, v);
    chk("stop_pc", v, 32'h148);
    memLat = 1;
    repeat (3) cyc();
    chk("stop_hold_halted", halted, 1'b1);
    chk("stop_hold_imReq", imReq, 1'b0);
    chk("stop_hold_pc", regData, 32'h148);
    run = 1'b1;
    cyc();
    chk("resume_imReq", imReq, 1'b1);
    chk("resume_imAddr", {2'b0, imAddr}, 32'h52);
    cyc();
    cyc();
    readReg(5'd17, v);
    chk("resume_x17", v, 32'd10);
    readReg(5'd0, v);
    chk("resume_pc", v, 32'h14C);

    // 3-cycle memory, beq self-loop: 4 cycles per instruction, address stable
    rst = 1'b0; rstPC = 32'h200; memLat = 3;
    cyc();
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("loop%0d_imReq", k), imReq, (k % 4) != 0);
      if (imReq === 1'b1) chk($sformatf("loop%0d_imAddr", k), {2'b0, imAddr}, 32'h80);
      chk($sformatf("loop%0d_pc", k), regData, 32'h200);
    end

    // fetch watchdog: never-valid memory
    rst = 1'b0; rstPC = 32'h400; memLat = 0;
    cyc();
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk($sformatf("to%0d_noErr", k), {imReq, fetchErr}, 32'b10);
    end
    cyc();
    chk("to_fetchErr", fetchErr, 1'b1);
    chk("to_imReq", imReq, 1'b0);
    chk("to_halted", halted, 1'b0);
    memLat = 1;
    repeat (4) cyc();
    chk("to_sticky", fetchErr, 1'b1);
    chk("to_pc", regData, 32'h400);
    chk("to_imReq_hold", imReq, 1'b0);
`ifdef DANO_MC_CPU_PERF_CNT_EN
    chk("to_perfFrozen", perfCycles, 32'd17);
    chk("to_instret", perfInstret, 32'd0);
`endif
    rst = 1'b0;
    cyc();
    chk("to_clear", fetchErr, 1'b0);
    chk("to_clear_halted", halted, 1'b1);

    // reset landing on EXEC drops the pending write
    rstPC = 32'h300; memLat = 1; run = 1'b1;
    cyc();
    rst = 1'b1;
    repeat (3) cyc();
    readReg(5'd20, v);
    chk("rx_x20_first", v, 32'h11);
    cyc();
    chk("rx_inExec_imReq", imReq, 1'b0);
    rst = 1'b0;
    cyc();
    readReg(5'd20, v);
    chk("rx_x20_kept", v, 32'h11);
    readReg(5'd0, v);
    chk("rx_pc", v, 32'h300);
    chk("rx_halted", halted, 1'b1);
`ifdef DANO_MC_CPU_PERF_CNT_EN
    chk("rx_perfCycles", perfCycles, 32'd0);
    chk("rx_perfInstret", perfInstret, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
